// File: rtl/pkt_mover_pkg.sv
// Shared types and constants for the packet mover read-side egress path.
//   egress_state_e : egress FSM states (HEADER consumes the length word,
//                    PAYLOAD streams the data beats).
//   HDR_LEN_LSB    : bit position of the length field in a header word.
//   HDR_LEN_W      : default width of the length field.
package pkt_mover_pkg;

  typedef enum logic [0:0] {
    HEADER  = 1'b0,
    PAYLOAD = 1'b1
  } egress_state_e;

  localparam int HDR_LEN_LSB = 0;
  localparam int HDR_LEN_W   = 16;

endpackage

// File: rtl/pkt_prefetch_buf.sv
// Two-entry synchronous prefetch buffer that absorbs the FIFO's registered
// read latency. The caller guarantees it never loads when full without a
// simultaneous deq and never deqs when empty.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_load     : write i_data into the tail this cycle
//   i_data     : word to store
//   i_deq      : consume the head this cycle
//   o_head     : current head word (meaningful when o_count != 0)
//   o_count    : occupancy, 0..2
module pkt_prefetch_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_deq,
  output logic [DATA_W-1:0] o_head,
  output logic [1:0]        o_count
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_load) r_wr_ptr <= ~r_wr_ptr;
      if (i_deq)  r_rd_ptr <= ~r_rd_ptr;
      // Load together with deq leaves the occupancy unchanged.
      case ({i_load, i_deq})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy and pointers
  // are, so stale contents are never observed and the array maps to plain flops.
  always_ff @(posedge clk) begin
    if (i_load) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/pkt_axis_egress.sv
// Read-side consumer of the packet mover's async FIFO. Pops FIFO words into a
// 2-entry prefetch buffer, strips the length header of each packet and emits
// the payload as an AXI4-Stream master with tlast on the final beat.
// Ports:
//   clk, rst_n          : FIFO read clock, synchronous active-low reset
//   fifo_rd_en          : pop request (never asserted while fifo_empty)
//   fifo_rd_data        : FIFO word, valid the cycle after an accepted pop
//   fifo_empty          : FIFO empty flag
//   m_axis_t*           : AXI4-Stream master (tvalid/tready/tdata/tlast)
//   pkt_done            : pulse on the tlast handshake
//   zero_len_err        : pulse when a length-0 header is discarded
//   pkt_cnt             : completed packets, wrapping
//   busy                : mid-packet or words held/in flight
module pkt_axis_egress
  import pkt_mover_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = HDR_LEN_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  input  logic              fifo_empty,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              pkt_done,
  output logic              zero_len_err,
  output logic [CNT_W-1:0]  pkt_cnt,
  output logic              busy
);

  egress_state_e     r_state;
  egress_state_e     w_state_nxt;
  logic [LEN_W-1:0]  r_remaining;
  logic              r_inflight;
  logic [CNT_W-1:0]  r_pkt_cnt;

  logic [DATA_W-1:0] w_head;
  logic [1:0]        w_count;
  logic              w_head_valid;
  logic              w_deq;
  logic              w_load;
  logic [LEN_W-1:0]  w_hdr_len;
  logic [2:0]        w_level;

  pkt_prefetch_buf #(.DATA_W(DATA_W)) u_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (fifo_rd_data),
    .i_deq   (w_deq),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // A word popped last cycle lands in the buffer now; clearing r_inflight on
  // reset drops a word that returns right after a mid-packet reset.
  assign w_load       = r_inflight;
  assign w_head_valid = (w_count != 2'd0);
  assign w_hdr_len    = w_head[HDR_LEN_LSB +: LEN_W];

  // Occupancy after this cycle's deq, counting the word still in flight.
  // Popping only while this is below 2 guarantees the buffer never overflows.
  assign w_level    = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign fifo_rd_en = rst_n & ~fifo_empty & (w_level < 3'd2);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= HEADER;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      HEADER:  if (w_head_valid && (w_hdr_len != '0)) w_state_nxt = PAYLOAD;
      PAYLOAD: if (pkt_done)                          w_state_nxt = HEADER;
      default: w_state_nxt = HEADER;
    endcase
  end

  // Output logic. tvalid depends only on registered state and buffer
  // occupancy, never on tready; the head stays put until deq, so tdata/tlast
  // are stable across stalls.
  // NOTE: every output gets a default first so no path through the case can
  // infer a latch.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    w_deq         = 1'b0;
    pkt_done      = 1'b0;
    zero_len_err  = 1'b0;
    case (r_state)
      HEADER: begin
        if (w_head_valid) begin
          w_deq        = 1'b1;
          zero_len_err = (w_hdr_len == '0);
        end
      end
      PAYLOAD: begin
        m_axis_tvalid = w_head_valid;
        m_axis_tdata  = w_head;
        m_axis_tlast  = w_head_valid & (r_remaining == LEN_W'(1));
        w_deq         = w_head_valid & m_axis_tready;
        pkt_done      = w_deq & m_axis_tlast;
      end
      default: ;
    endcase
  end

  // Datapath: remaining-beat counter, pop tracking, packet counter.
  // remaining is only decremented in PAYLOAD while >= 1 and PAYLOAD is left at
  // 1, so it cannot wrap even for the maximum length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_pkt_cnt   <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      if (w_deq) begin
        if (r_state == HEADER) r_remaining <= w_hdr_len;
        else                   r_remaining <= r_remaining - LEN_W'(1);
      end
      if (pkt_done) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign busy    = (r_state == PAYLOAD) | w_head_valid | r_inflight;

endmodule

// File: tb/tb_pkt_axis_egress.sv
// Scoreboard bench for pkt_axis_egress: stimulus pushes FIFO words and the
// expected beats; a monitor pops and compares on every AXI handshake.
module tb_pkt_axis_egress;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data = '0;
  logic              fifo_empty = 1'b1;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              pkt_done;
  logic              zero_len_err;
  logic [CNT_W-1:0]  pkt_cnt;
  logic              busy;

  // FIFO model: stimulus owns fifo_mem/wr_ptr, the clocked model owns rd_ptr.
  logic [DATA_W-1:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  beat_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int mon_cyc  = 0;
  int beats_total = 0;
  int zle_cnt  = 0;
  int done_cnt = 0;
  int empty_fall_cyc = 0;
  int beat_cyc [0:63];
  int exp_pkt_cnt = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;
  logic              prev_last  = 1'b0;
  logic              prev_empty = 1'b1;

  pkt_axis_egress #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_empty    (fifo_empty),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_done      (pkt_done),
    .zero_len_err  (zero_len_err),
    .pkt_cnt       (pkt_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr = wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr % 256];
      rd_ptr = rd_ptr + 1;
    end
    fifo_empty <= (rd_ptr == wr_ptr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    fifo_mem[wr_ptr % 256] = w;
    wr_ptr++;
  endtask

  task automatic push_hdr(input int len);
    push_word({16'hBEEF, 16'(len)});
    if (len == 0) return;
    exp_pkt_cnt++;
  endtask

  task automatic push_payload(input logic [DATA_W-1:0] base, input int first, input int n, input int len);
    beat_t b;
    for (int i = first; i < first + n; i++) begin
      push_word(base + DATA_W'(i));
      b.data = base + DATA_W'(i);
      b.last = (i == len - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic send_pkt(input int len, input logic [DATA_W-1:0] base);
    push_hdr(len);
    push_payload(base, 0, len, len);
  endtask

  task automatic wait_beats(input string name, input int target);
    int k = 0;
    while (beats_total < target && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({name, "_beat_timeout"}, 64'(beats_total >= target), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((busy || exp_q.size() != 0 || rd_ptr != wr_ptr) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({name, "_idle_timeout"}, 64'(busy), 64'd0);
    check({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_tvalid"},   64'(m_axis_tvalid), 64'd0);
    check({name, "_tlast"},    64'(m_axis_tlast),  64'd0);
    check({name, "_tdata"},    64'(m_axis_tdata),  64'd0);
    check({name, "_pkt_done"}, 64'(pkt_done),      64'd0);
    check({name, "_zle"},      64'(zero_len_err),  64'd0);
    check({name, "_rd_en"},    64'(fifo_rd_en),    64'd0);
    check({name, "_pkt_cnt"},  64'(pkt_cnt),       64'd0);
    check({name, "_busy"},     64'(busy),          64'd0);
  endtask

  // Monitor: samples 2 time units after the negedge, once inputs have settled.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      mon_cyc++;
      if (!rst_n) begin
        prev_stall = 1'b0;
        prev_empty = 1'b1;
      end else begin
        if (prev_empty && !fifo_empty) empty_fall_cyc = mon_cyc;
        prev_empty = fifo_empty;
        if (fifo_rd_en) check("rd_en_while_empty", 64'(fifo_empty), 64'd0);
        if (dut.w_load) check("buf_overflow", 64'(dut.w_count == 2'd2 && !dut.w_deq), 64'd0);
        if (prev_stall) begin
          check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
          check("stall_tdata",  64'(m_axis_tdata),  64'(prev_data));
          check("stall_tlast",  64'(m_axis_tlast),  64'(prev_last));
        end
        prev_stall = m_axis_tvalid & ~m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready) begin
          check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("tdata",    64'(m_axis_tdata), 64'(e.data));
            check("tlast",    64'(m_axis_tlast), 64'(e.last));
            check("pkt_done", 64'(pkt_done),     64'(e.last));
          end
          beat_cyc[beats_total % 64] = mon_cyc;
          beats_total++;
        end else begin
          check("pkt_done_no_hs", 64'(pkt_done), 64'd0);
        end
        if (pkt_done) done_cnt++;
        if (zero_len_err) zle_cnt++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int d0;
    int z0;
    int k;
    logic [6:0] pat;

    // Reset state
    rst_n = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("reset");

    // 1: single 3-beat packet, tready held high
    @(negedge clk);
    m_axis_tready = 1'b1;
    b0 = beats_total;
    d0 = done_cnt;
    send_pkt(3, 32'hA000_0000);
    wait_beats("t1", b0 + 3);
    check("t1_latency",     64'(beat_cyc[b0 % 64] - empty_fall_cyc), 64'd3);
    check("t1_consecutive", 64'(beat_cyc[(b0 + 2) % 64] - beat_cyc[b0 % 64]), 64'd2);
    wait_idle("t1");
    check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
    check("t1_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    // 2: back-to-back packets, one header bubble between them
    b0 = beats_total;
    send_pkt(2, 32'hD000_0000);
    send_pkt(1, 32'hE000_0000);
    wait_beats("t2", b0 + 3);
    check("t2_d_gap",      64'(beat_cyc[(b0 + 1) % 64] - beat_cyc[b0 % 64]), 64'd1);
    check("t2_hdr_bubble", 64'(beat_cyc[(b0 + 2) % 64] - beat_cyc[(b0 + 1) % 64]), 64'd2);
    wait_idle("t2");
    check("t2_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    // 3: tready pattern 1,0,0,1,0,1,1 applied from the first valid beat
    m_axis_tready = 1'b0;
    b0 = beats_total;
    send_pkt(4, 32'h4000_0000);
    k = 0;
    while (!m_axis_tvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("t3_tvalid_timeout", 64'(m_axis_tvalid), 64'd1);
    pat = 7'b1101001;
    for (int i = 0; i < 7; i++) begin
      m_axis_tready = pat[i];
      @(negedge clk);
    end
    check("t3_beats", 64'(beats_total - b0), 64'd4);
    m_axis_tready = 1'b1;
    wait_idle("t3");
    check("t3_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    // 4: zero-length header discarded, then a 1-beat packet
    z0 = zle_cnt;
    b0 = beats_total;
    send_pkt(0, 32'h0);
    send_pkt(1, 32'hF000_0000);
    wait_beats("t4", b0 + 1);
    wait_idle("t4");
    check("t4_zle_pulses", 64'(zle_cnt - z0), 64'd1);
    check("t4_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    // 5: FIFO underflow mid-packet for 10 cycles
    b0 = beats_total;
    push_hdr(5);
    push_payload(32'h5000_0000, 0, 2, 5);
    wait_beats("t5a", b0 + 2);
    repeat (5) @(negedge clk);
    check("t5_gap_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t5_gap_busy",   64'(busy), 64'd1);
    repeat (5) @(negedge clk);
    push_payload(32'h5000_0000, 2, 3, 5);
    wait_beats("t5b", b0 + 5);
    wait_idle("t5");
    check("t5_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    // 6: reset after 2 of 4 beats, then a fresh packet
    b0 = beats_total;
    send_pkt(4, 32'h6000_0000);
    wait_beats("t6a", b0 + 2);
    m_axis_tready = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    exp_pkt_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("midreset");
    @(negedge clk);
    m_axis_tready = 1'b1;
    b0 = beats_total;
    send_pkt(1, 32'h6600_0000);
    wait_beats("t6b", b0 + 1);
    wait_idle("t6");
    check("t6_pkt_cnt", 64'(pkt_cnt), 64'(exp_pkt_cnt));

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pkt_axis_egress.md
Name: pkt_axis_egress

Overview:
Read-side consumer of the packet mover's async FIFO, running in the FIFO read clock domain. It pops FIFO words and absorbs the FIFO's one-cycle registered-read latency in a 2-entry prefetch buffer. It strips a length header word from each packet and emits the payload as an AXI4-Stream master with correct tlast. It sustains 1 beat/cycle across packet payloads, with a 1-cycle header bubble per packet.

Parameters:
DATA_W, 32, FIFO word and tdata width
LEN_W, 16, header length field width; must be <= DATA_W
CNT_W, 16, width of completed-packet counter

Ports:
clk  in  1  single clock (FIFO read clock)
rst_n  in  1  reset, synchronous, active-low
fifo_rd_en  out  1  pop request to FIFO read port
fifo_rd_data  in  DATA_W  FIFO read data; valid the cycle after an accepted pop
fifo_empty  in  1  FIFO empty flag
m_axis_tvalid  out  1  AXI-Stream valid
m_axis_tready  in  1  AXI-Stream ready
m_axis_tdata  out  DATA_W  payload beat
m_axis_tlast  out  1  final beat of packet
pkt_done  out  1  1-cycle pulse on the tlast handshake
zero_len_err  out  1  1-cycle pulse when a length-0 header is discarded
pkt_cnt  out  CNT_W  completed packets, wraps to 0
busy  out  1  FSM in PAYLOAD, or buffer/in-flight nonzero

Behaviour:
- Reset (clk edge with rst_n=0): all outputs 0; buffer empty; inflight=0; FSM=HEADER; pkt_cnt=0.
- Interface timing (decided): one clock; reset is synchronous and active-low, ports clk/rst_n.
- Pop accounting: pop = fifo_rd_en & ~fifo_empty. Set inflight=1 on pop; the word is written into the buffer tail the next cycle.
- fifo_rd_en = ~fifo_empty & ((count + inflight - deq) < 2).
  - count: buffer occupancy (0..2).
  - deq: buffer head consumed this cycle.
  - Never asserted while fifo_empty=1. The buffer must never overflow; a bench assertion checks this.
- Word format: the first word of each packet is the header, with payload length in bits [LEN_W-1:0]. Higher header bits are ignored. Exactly len payload words follow.
- FSM HEADER:
  - m_axis_tvalid=0.
  - If the buffer head is valid: deq it and latch remaining=len.
  - If len=0: pulse zero_len_err and stay in HEADER.
  - Otherwise go to PAYLOAD.
- FSM PAYLOAD:
  - m_axis_tvalid = head valid; m_axis_tdata = head; m_axis_tlast = (remaining==1).
  - On tvalid & tready: deq, remaining--.
  - If that beat is last: pulse pkt_done, increment pkt_cnt (modulo 2^CNT_W), go to HEADER.
- AXI rules:
  - Once tvalid=1, tvalid/tdata/tlast stay stable until the handshake.
  - tvalid does not depend combinationally on tready.
  - tready may toggle freely; no beats are lost or duplicated.
- Latency: first payload beat appears 3 cycles after fifo_empty falls with a header then payload present (pop, buffer load, header consume).
- Boundaries:
  - FIFO underflow mid-packet: tvalid drops and resumes, and remaining is held.
  - Max length 2^LEN_W-1 supported. The remaining counter is LEN_W bits and must not wrap.
  - Back-to-back packets: the next header may already sit in the buffer, costing exactly 1 bubble cycle.
  - Simultaneous load and deq with count=1 keeps count=1.
- Reset mid-packet: buffer, inflight and FSM are cleared, and a FIFO word returning the next cycle is dropped. Integration requires the FIFO read side to be reset in the same cycle.

Decomposition:
- Package pkt_mover_pkg: typedef egress_state_e {HEADER, PAYLOAD}; localparams for header length field position (HDR_LEN_LSB=0) and HDR_LEN_W.
- One sub-module: pkt_prefetch_buf, a 2-entry synchronous buffer (load, deq, head, count). The FSM and pop control stay in pkt_axis_egress.

Test Plan:
- FIFO holds [hdr=3, A, B, C], tready=1 constantly → beats A,B,C on consecutive cycles, tlast only on C, pkt_done one pulse, pkt_cnt=1.
- Packets [hdr=2,D0,D1][hdr=1,E0] back-to-back, tready=1 → D0,D1,bubble,E0; tlast on D1 and E0; pkt_cnt=2.
- hdr=4 payload with tready pattern 1,0,0,1,0,1,1 → exactly 4 beats in order, tdata/tlast stable while stalled, fifo_rd_en never causes buffer overflow.
- Sequence [hdr=0][hdr=1,F0] → zero_len_err pulses once, no output for length-0, then F0 with tlast; pkt_cnt=1.
- hdr=5, FIFO runs empty after 2 payload words for 10 cycles, then refills → tvalid low during gap, remaining beats delivered, tlast on 5th.
- rst_n low for 1 cycle after 2 of 4 beats of a packet → all outputs 0, pkt_cnt=0, busy=0; next fresh packet [hdr=1,G0] emitted correctly.
